// File: rtl/fei4_frame_builder.sv
// FE-I4 output framing stage feeding the 8b10b encoder: K28.1 idles, K28.7 SOF, 3 data bytes per record, K28.5 EOF.
// Optional FEI4_FRAME_STATS_EN adds saturating frame_count / underrun_count outputs.
module fei4_frame_builder #(
  parameter int BYTE_DIV = 4,
  parameter int MIN_IDLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] rec_data,
  input  logic        rec_last,
  input  logic        rec_valid,
  output logic        rec_ready,
  output logic [7:0]  enc_data,
  output logic        enc_k,
  output logic        enc_dispin,
  input  logic        enc_dispout,
  output logic        byte_tick,
  output logic        underrun
`ifdef FEI4_FRAME_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] underrun_count
`endif
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SOF  = 3'd1;
  localparam logic [2:0] ST_D0   = 3'd2;
  localparam logic [2:0] ST_D1   = 3'd3;
  localparam logic [2:0] ST_D2   = 3'd4;
  localparam logic [2:0] ST_EOF  = 3'd5;

  localparam logic [7:0] K28_1    = 8'h3C;
  localparam logic [7:0] K28_5    = 8'hBC;
  localparam logic [7:0] K28_7    = 8'hFC;
  localparam logic [7:0] DIV_LAST = 8'(BYTE_DIV - 1);
  localparam logic [3:0] IDLE_MIN = 4'(MIN_IDLE);

  logic [7:0]  r_div;
  logic [2:0]  r_state;
  logic [3:0]  r_idle_cnt;
  logic [23:0] r_rec;
  logic        r_last;
  logic [7:0]  r_enc_data;
  logic        r_enc_k;
  logic        r_dispin;
  logic        r_ready;
  logic        r_tick;
  logic        r_underrun;

  logic        w_boundary;
  logic        w_accept;
  logic        w_underrun;
  logic [2:0]  w_next_state;
  logic [3:0]  w_idle_inc;
  logic [7:0]  w_byte;
  logic        w_k;

  assign w_boundary = (r_div == DIV_LAST);
  // The idle byte being presented counts toward the gap, so SOF is judged on the incremented value.
  assign w_idle_inc = (r_idle_cnt == 4'd15) ? 4'd15 : r_idle_cnt + 4'd1;

  assign rec_ready  = r_ready;
  assign enc_data   = r_enc_data;
  assign enc_k      = r_enc_k;
  assign enc_dispin = r_dispin;
  assign byte_tick  = r_tick;
  assign underrun   = r_underrun;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_underrun   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rec_valid && (w_idle_inc >= IDLE_MIN)) begin
          w_next_state = ST_SOF;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SOF: begin
        w_next_state = ST_D0;
        w_accept     = 1'b1;
      end
      ST_D0: w_next_state = ST_D1;
      ST_D1: w_next_state = ST_D2;
      ST_D2: begin
        if (r_last) begin
          w_next_state = ST_EOF;
        end else if (rec_valid) begin
          w_next_state = ST_D0;
          w_accept     = 1'b1;
        end else begin
          w_next_state = ST_EOF;
          w_underrun   = 1'b1;
        end
      end
      ST_EOF:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // D0 takes its byte straight from the input because the record is latched in the same cycle.
  always_comb begin
    w_byte = K28_1;
    w_k    = 1'b1;
    case (w_next_state)
      ST_IDLE: begin w_byte = K28_1;           w_k = 1'b1; end
      ST_SOF:  begin w_byte = K28_7;           w_k = 1'b1; end
      ST_D0:   begin w_byte = rec_data[23:16]; w_k = 1'b0; end
      ST_D1:   begin w_byte = r_rec[15:8];     w_k = 1'b0; end
      ST_D2:   begin w_byte = r_rec[7:0];      w_k = 1'b0; end
      ST_EOF:  begin w_byte = K28_5;           w_k = 1'b1; end
      default: begin w_byte = K28_1;           w_k = 1'b1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div      <= 8'd0;
      r_state    <= ST_IDLE;
      r_idle_cnt <= IDLE_MIN;
      r_rec      <= 24'd0;
      r_last     <= 1'b0;
      r_enc_data <= K28_1;
      r_enc_k    <= 1'b1;
      r_dispin   <= 1'b0;
      r_ready    <= 1'b0;
      r_tick     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_div      <= w_boundary ? 8'd0 : r_div + 8'd1;
      r_tick     <= w_boundary;
      r_ready    <= w_boundary & w_accept;
      r_underrun <= w_boundary & w_underrun;
      if (w_boundary) begin
        r_state    <= w_next_state;
        r_enc_data <= w_byte;
        r_enc_k    <= w_k;
        r_dispin   <= enc_dispout;
        if (w_accept) begin
          r_rec  <= rec_data;
          r_last <= rec_last;
        end
        if (r_state == ST_IDLE) begin
          r_idle_cnt <= w_idle_inc;
        end else if (r_state == ST_EOF) begin
          r_idle_cnt <= 4'd0;
        end
      end
    end
  end

`ifdef FEI4_FRAME_STATS_EN
  logic [15:0] r_frame_count;
  logic [15:0] r_underrun_count;

  assign frame_count    = r_frame_count;
  assign underrun_count = r_underrun_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_count    <= 16'd0;
      r_underrun_count <= 16'd0;
    end else begin
      if (w_boundary && (w_next_state == ST_EOF) && (r_state != ST_EOF) &&
          (r_frame_count != 16'hFFFF)) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_boundary && w_underrun && (r_underrun_count != 16'hFFFF)) begin
        r_underrun_count <= r_underrun_count + 16'd1;
      end
    end
  end
`endif

endmodule
